// File: rtl/pushbutton_command_unit_if.sv
// rtl/pushbutton_command_unit_if.sv - pushbutton command unit signal bundle
interface pushbutton_command_unit_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       pushbuttons;
  logic             pushButtonPressed;
  logic [WIDTH-1:0] current_value;
  logic             result_ready;
  logic [WIDTH-1:0] result_value;
  logic             result_valid;
  logic             backspace_pulse;
  logic             command_accepted;
  logic [WIDTH-1:0] memory_value;
  logic             memory_valid;

  // Decoder / entry-path side: drives buttons, value and ready.
  modport master (
    output pushbuttons, pushButtonPressed, current_value, result_ready,
    input  result_value, result_valid, backspace_pulse, command_accepted,
           memory_value, memory_valid
  );

  // Command unit side.
  modport slave (
    input  pushbuttons, pushButtonPressed, current_value, result_ready,
    output result_value, result_valid, backspace_pulse, command_accepted,
           memory_value, memory_valid
  );
endinterface

// File: rtl/pushbutton_command_unit.sv
// rtl/pushbutton_command_unit.sv - debounced one-command-per-press memory unit
module pushbutton_command_unit #(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 4
) (
  input logic                    clock,
  input logic                    reset,
  pushbutton_command_unit_if.slave bus
);
  localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);

  localparam logic [1:0] CODE_BACKSPACE = 2'b00;
  localparam logic [1:0] CODE_MS        = 2'b01;
  localparam logic [1:0] CODE_MR        = 2'b10;
  localparam logic [1:0] CODE_MC        = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    EXECUTE  = 3'd2,
    OUTPUT   = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       count;
  logic [1:0]       code;
  logic [WIDTH-1:0] memory_q;
  logic             memory_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic             accepted_q;
  logic             backspace_q;

  // Command FSM: debounce, execute exactly once, hold recall, wait for release.
  // The strobes are set on the edge that enters EXECUTE so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 8'd0;
      code           <= 2'b00;
      memory_q       <= '0;
      memory_valid_q <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      accepted_q     <= 1'b0;
      backspace_q    <= 1'b0;
    end else begin
      accepted_q  <= 1'b0;
      backspace_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.pushButtonPressed) begin
            code  <= bus.pushbuttons;
            count <= 8'd1;
            if (HOLD == 8'd1) begin
              state       <= EXECUTE;
              accepted_q  <= 1'b1;
              backspace_q <= (bus.pushbuttons == CODE_BACKSPACE);
            end else begin
              state <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!bus.pushButtonPressed || bus.pushbuttons != code) begin
            state <= IDLE;
            count <= 8'd0;
          end else if (count >= HOLD - 8'd1) begin
            // This sample completes the hold window.
            state       <= EXECUTE;
            count       <= 8'd0;
            accepted_q  <= 1'b1;
            backspace_q <= (code == CODE_BACKSPACE);
          end else if (count != 8'hFF) begin
            count <= count + 8'd1;
          end
        end
        EXECUTE: begin
          state <= RELEASE;
          case (code)
            CODE_MS: begin
              memory_q       <= bus.current_value;
              memory_valid_q <= 1'b1;
            end
            CODE_MR: begin
              if (memory_valid_q) begin
                result_q       <= memory_q;
                result_valid_q <= 1'b1;
                state          <= OUTPUT;
              end
            end
            CODE_MC: begin
              memory_q       <= '0;
              memory_valid_q <= 1'b0;
            end
            default: ;
          endcase
        end
        OUTPUT: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus.pushButtonPressed) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_value     = result_q;
  assign bus.result_valid     = result_valid_q;
  assign bus.backspace_pulse  = backspace_q;
  assign bus.command_accepted = accepted_q;
  assign bus.memory_value     = memory_q;
  assign bus.memory_valid     = memory_valid_q;
endmodule

// File: tb/tb_pushbutton_command_unit.sv
// tb/tb_pushbutton_command_unit.sv - self-checking bench for pushbutton_command_unit
module tb_pushbutton_command_unit;
  localparam int W    = 16;
  localparam int HOLD = 4;

  logic clock;
  logic reset;

  pushbutton_command_unit_if #(.WIDTH(W)) bus ();

  pushbutton_command_unit #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert;
  int n_fail;

  // Reference model: a press fires once its stable run of samples reaches HOLD;
  // a fired press locks the buttons out until a released sample is seen.
  int           m_run;
  logic [1:0]   m_code;
  bit           m_fire;
  bit           m_lock;
  bit           m_ca;
  bit           m_bs;
  logic [W-1:0] m_mem;
  bit           m_memv;
  logic [W-1:0] m_res;
  bit           m_resv;

  int  ca_count;
  int  bs_count;
  int  rv_count;
  bit  prev_ca;
  bit  prev_bs;

  task automatic model_clear();
    m_run = 0; m_code = 2'b00; m_fire = 0; m_lock = 0; m_ca = 0; m_bs = 0;
    m_mem = '0; m_memv = 0; m_res = '0; m_resv = 0;
  endtask

  task automatic model_edge(input bit p, input logic [1:0] c,
                            input logic [W-1:0] cur, input bit rdy);
    bit fire_now;
    fire_now = 0;
    m_ca = 0;
    m_bs = 0;
    if (m_fire) begin
      m_fire = 0;
      m_lock = 1;
      if (m_code == 2'b01) begin
        m_mem = cur; m_memv = 1;
      end else if (m_code == 2'b10 && m_memv) begin
        m_res = m_mem; m_resv = 1;
      end else if (m_code == 2'b11) begin
        m_mem = '0; m_memv = 0;
      end
    end else if (m_resv) begin
      if (rdy) m_resv = 0;
    end else if (m_lock) begin
      if (!p) m_lock = 0;
    end else if (m_run == 0) begin
      if (p) begin
        m_run = 1; m_code = c;
        if (m_run >= HOLD) fire_now = 1;
      end
    end else if (p && c == m_code) begin
      m_run++;
      if (m_run >= HOLD) fire_now = 1;
    end else begin
      m_run = 0;
    end
    if (fire_now) begin
      m_fire = 1; m_ca = 1; m_bs = (m_code == 2'b00); m_run = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("command_accepted", 32'(bus.command_accepted), 32'(m_ca));
    chk("backspace_pulse", 32'(bus.backspace_pulse), 32'(m_bs));
    chk("result_valid", 32'(bus.result_valid), 32'(m_resv));
    chk("result_value", 32'(bus.result_value), 32'(m_res));
    chk("memory_value", 32'(bus.memory_value), 32'(m_mem));
    chk("memory_valid", 32'(bus.memory_valid), 32'(m_memv));
    chk("ca_not_repeated", 32'(prev_ca && bus.command_accepted), 32'd0);
    chk("bs_not_repeated", 32'(prev_bs && bus.backspace_pulse), 32'd0);
    prev_ca = bus.command_accepted;
    prev_bs = bus.backspace_pulse;
    if (bus.command_accepted === 1'b1) ca_count++;
    if (bus.backspace_pulse === 1'b1)  bs_count++;
    if (bus.result_valid === 1'b1)     rv_count++;
  endtask

  // One clock: drive on the falling edge, model on the rising edge, check 1 ns later.
  task automatic step(input bit p, input logic [1:0] c,
                      input logic [W-1:0] cur, input bit rdy);
    @(negedge clock);
    bus.pushButtonPressed = p;
    bus.pushbuttons       = c;
    bus.current_value     = cur;
    bus.result_ready      = rdy;
    @(posedge clock);
    if (reset) model_clear();
    else model_edge(p, c, cur, rdy);
    #1;
    check_all();
  endtask

  task automatic press(input logic [1:0] c, input int n,
                       input logic [W-1:0] cur, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, c, cur, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic clear_counts();
    ca_count = 0; bs_count = 0; rv_count = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    prev_ca = 0; prev_bs = 0;
    clear_counts();
    model_clear();
    bus.pushButtonPressed = 1'b0;
    bus.pushbuttons       = 2'b00;
    bus.current_value     = '0;
    bus.result_ready      = 1'b0;

    // Reset state
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("reset_memory_valid", 32'(bus.memory_valid), 32'd0);
    chk("reset_result_valid", 32'(bus.result_valid), 32'd0);
    idle(1);

    // 1: MS then MR
    clear_counts();
    press(2'b01, 6, 16'h1234, 1'b1);
    idle(2);
    chk("s1_memory_value", 32'(bus.memory_value), 32'h1234);
    chk("s1_memory_valid", 32'(bus.memory_valid), 32'd1);
    press(2'b10, 6, 16'h0000, 1'b1);
    idle(3);
    chk("s1_ca_pulses", 32'(ca_count), 32'd2);
    chk("s1_rv_cycles", 32'(rv_count), 32'd1);

    // 2: bounce rejection, then a clean 4-sample hold
    clear_counts();
    step(1, 2'b00, '0, 1); step(1, 2'b00, '0, 1); step(0, 2'b00, '0, 1);
    step(1, 2'b00, '0, 1); step(1, 2'b00, '0, 1); step(1, 2'b00, '0, 1);
    step(0, 2'b00, '0, 1);
    chk("s2_bounce_ca", 32'(ca_count), 32'd0);
    chk("s2_bounce_bs", 32'(bs_count), 32'd0);
    press(2'b00, 4, '0, 1'b1);
    chk("s2_bs_after_4th", 32'(bus.backspace_pulse), 32'd1);
    idle(2);
    chk("s2_bs_pulses", 32'(bs_count), 32'd1);

    // 3: long hold with a code change to MC mid-hold
    clear_counts();
    for (int i = 0; i < 50; i++) step(1'b1, (i < 20) ? 2'b00 : 2'b11, '0, 1'b1);
    idle(2);
    chk("s3_bs_pulses", 32'(bs_count), 32'd1);
    chk("s3_ca_pulses", 32'(ca_count), 32'd1);
    chk("s3_memory_kept", 32'(bus.memory_value), 32'h1234);
    chk("s3_memory_valid", 32'(bus.memory_valid), 32'd1);

    // 4: backpressure on recall
    press(2'b01, 5, 16'hBEEF, 1'b0);
    idle(2);
    press(2'b10, 5, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00, '0, 1'b0);
      chk("s4_hold_valid", 32'(bus.result_valid), 32'd1);
      chk("s4_hold_value", 32'(bus.result_value), 32'hBEEF);
    end
    step(1'b0, 2'b00, '0, 1'b1);
    chk("s4_valid_dropped", 32'(bus.result_valid), 32'd0);
    idle(2);

    // 5: MR on empty memory, then MS and MC
    reset = 1'b1; idle(1); reset = 1'b0;
    clear_counts();
    press(2'b10, 5, '0, 1'b1);
    idle(2);
    chk("s5_empty_ca", 32'(ca_count), 32'd1);
    chk("s5_empty_rv", 32'(rv_count), 32'd0);
    press(2'b01, 5, 16'h00FF, 1'b1);
    idle(2);
    chk("s5_ms_value", 32'(bus.memory_value), 32'h00FF);
    press(2'b11, 5, '0, 1'b1);
    idle(2);
    chk("s5_mc_value", 32'(bus.memory_value), 32'h0000);
    chk("s5_mc_valid", 32'(bus.memory_valid), 32'd0);

    // 6: reset while a recall is pending
    press(2'b01, 5, 16'h5A5A, 1'b0);
    idle(2);
    press(2'b10, 5, '0, 1'b0);
    chk("s6_pending", 32'(bus.result_valid), 32'd1);
    reset = 1'b1;
    step(1'b0, 2'b00, '0, 1'b0);
    reset = 1'b0;
    chk("s6_rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("s6_rst_memory_valid", 32'(bus.memory_valid), 32'd0);
    chk("s6_rst_memory_value", 32'(bus.memory_value), 32'd0);
    clear_counts();
    press(2'b00, 5, '0, 1'b1);
    idle(2);
    chk("s6_clean_press_bs", 32'(bs_count), 32'd1);

    // Randomized presses, bounces, code changes and ready patterns
    for (int b = 0; b < 120; b++) begin
      logic [1:0]   c;
      logic [W-1:0] cur;
      int           len;
      c   = 2'($urandom_range(0, 3));
      cur = W'($urandom);
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        bit p;
        logic [1:0] cc;
        p  = ($urandom_range(0, 9) != 0);
        cc = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : c;
        step(p, cc, cur, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < $urandom_range(0, 3); i++)
        step(1'b0, 2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
